// File: rtl/lisa_program_loader.sv
// lisa_program_loader: framed byte-stream loader for the LISA core's instruction memory.
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CSUM.
// The core is held in reset from SYNC until the checksum has verified.
module lisa_program_loader #(
    parameter int unsigned MEM_BYTES = 512,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        prog_we,
    output logic [15:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] bytes_written
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned EW = AW + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  base_q, base_d;
    logic [AW-1:0]  len_q, len_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [DW-1:0]  sum_q, sum_d;
    logic           ready_q, ready_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           core_rst_q, core_rst_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [AW-1:0]  bw_q, bw_d;

    logic           accept;
    logic [AW-1:0]  len_full;
    logic [EW-1:0]  end_addr;
    logic [DW-1:0]  sum_in;

    assign accept   = in_valid && ready_q;
    assign len_full = {len_q[AW-1:DW], in_data};
    // 17-bit end address so base+len cannot wrap past the range check
    assign end_addr = EW'(base_q) + EW'(len_full);
    assign sum_in   = sum_q + in_data;

    // State and output registers; reset holds the core and idles the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bw_q       <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            bw_q       <= bw_d;
        end
    end

    // Frame parser: next state, header capture, payload writes and verdict
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        ready_d    = 1'b1;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        bw_d       = bw_q;

        if (accept) begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d    = S_ADDR_H;
                        core_rst_d = 1'b1;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        bw_d       = '0;
                        sum_d      = '0;
                    end
                end
                S_ADDR_H: begin
                    base_d  = {in_data, base_q[DW-1:0]};
                    sum_d   = sum_in;
                    state_d = S_ADDR_L;
                end
                S_ADDR_L: begin
                    base_d  = {base_q[AW-1:DW], in_data};
                    sum_d   = sum_in;
                    state_d = S_LEN_H;
                end
                S_LEN_H: begin
                    len_d   = {in_data, len_q[DW-1:0]};
                    sum_d   = sum_in;
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    len_d = len_full;
                    sum_d = sum_in;
                    idx_d = '0;
                    if (len_full == '0 || end_addr > EW'(MEM_BYTES)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    we_d   = 1'b1;
                    addr_d = base_q + idx_q;
                    data_d = in_data;
                    bw_d   = bw_q + AW'(1);
                    sum_d  = sum_in;
                    idx_d  = idx_q + AW'(1);
                    if (idx_q + AW'(1) == len_q) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (sum_in == '0) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        core_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_ready      = ready_q;
    assign prog_we       = we_q;
    assign prog_addr     = addr_q;
    assign prog_data     = data_q;
    assign core_rst      = core_rst_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign bytes_written = bw_q;

endmodule

// File: tb/tb_lisa_program_loader.sv
// Bench for lisa_program_loader: frame-level reference model checked every cycle,
// plus literal checks on the write log and status flags after each scenario.
module tb_lisa_program_loader;

    localparam int unsigned MEM = 512;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, prog_we, core_rst, load_done, load_err;
    logic [15:0] prog_addr, bytes_written;
    logic [7:0]  prog_data;

    lisa_program_loader #(.MEM_BYTES(MEM), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .core_rst(core_rst), .load_done(load_done),
        .load_err(load_err), .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: keeps the bytes of the current frame and decides by position
    logic        m_ready = 1'b0, m_we = 1'b0, m_rst = 1'b1, m_done = 1'b0, m_err = 1'b0;
    logic [15:0] m_addr = '0, m_bw = '0;
    logic [7:0]  m_data = '0;
    bit          in_frame = 0;
    logic [7:0]  fr[$];

    task automatic model_byte(input logic [7:0] b);
        int n, base, len, s;
        if (!in_frame) begin
            if (b == SYNC) begin
                in_frame = 1; fr.delete();
                m_rst = 1; m_done = 0; m_err = 0; m_bw = 0;
            end
        end else begin
            fr.push_back(b);
            n = fr.size();
            base = 0; len = 0;
            if (n >= 4) begin
                base = int'(fr[0]) * 256 + int'(fr[1]);
                len  = int'(fr[2]) * 256 + int'(fr[3]);
            end
            if (n == 4) begin
                if (len == 0 || base + len > int'(MEM)) begin m_err = 1; in_frame = 0; end
            end else if (n > 4 && n <= 4 + len) begin
                m_we = 1; m_addr = 16'(base + n - 5); m_data = b; m_bw = 16'(n - 4);
            end else if (n == 5 + len) begin
                s = 0;
                foreach (fr[i]) s += int'(fr[i]);
                if (s % 256 == 0) begin m_done = 1; m_rst = 0; end
                else m_err = 1;
                in_frame = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_we = 0; m_addr = 0; m_data = 0; m_rst = 1;
            m_done = 0; m_err = 0; m_bw = 0; in_frame = 0; fr.delete();
        end else begin
            bit acc;
            acc = in_valid && m_ready;
            m_ready = 1; m_we = 0;
            if (acc) model_byte(in_data);
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge
    logic [23:0] wlog[$];
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("prog_we", 32'(prog_we), 32'(m_we));
        chk("core_rst", 32'(core_rst), 32'(m_rst));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("bytes_written", 32'(bytes_written), 32'(m_bw));
        if (m_we || !rst_n) begin
            chk("prog_addr", 32'(prog_addr), 32'(m_addr));
            chk("prog_data", 32'(prog_data), 32'(m_data));
        end
        if (prog_we === 1'b1) wlog.push_back({prog_addr, prog_data});
    end

    logic [7:0] stim[$];

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stim(input int maxgap);
        foreach (stim[i]) send(stim[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_log(input string name, input int n, input logic [23:0] e0,
                             input logic [23:0] e1, input logic [23:0] e2);
        logic [23:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({name, "_nwrites"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < 3; i++)
            if (i < wlog.size()) chk({name, "_write"}, 32'(wlog[i]), 32'(e[i]));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Good load: 0x10+0x03+0x11+0x22+0x33 = 0x79, so CSUM = 0x87
        wlog.delete();
        stim = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_stim(0);
        @(negedge clk); #1;
        chk("good_done", 32'(load_done), 32'd1);
        chk("good_core_rst", 32'(core_rst), 32'd0);
        chk("good_bw", 32'(bytes_written), 32'd3);
        check_log("good", 3, 24'h001011, 24'h001122, 24'h001233);

        // Bad checksum
        wlog.delete();
        stim = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h86};
        send_stim(0);
        @(negedge clk); #1;
        chk("bad_err", 32'(load_err), 32'd1);
        chk("bad_done", 32'(load_done), 32'd0);
        chk("bad_core_rst", 32'(core_rst), 32'd1);
        check_log("bad", 3, 24'h001011, 24'h001122, 24'h001233);

        // Range reject: 0x01FF + 2 = 513 > 512; trailing bytes are dropped in ERR
        wlog.delete();
        stim = '{8'hA5, 8'h01, 8'hFF, 8'h00, 8'h02, 8'hAB, 8'hCD};
        send_stim(0);
        @(negedge clk); #1;
        chk("range_err", 32'(load_err), 32'd1);
        check_log("range", 0, 24'h0, 24'h0, 24'h0);

        // Exact fit at the top of memory: 0x01FE + 2 = 512 is accepted
        wlog.delete();
        stim = '{8'hA5, 8'h01, 8'hFE, 8'h00, 8'h02, 8'h01, 8'h02, 8'h00};
        stim[7] = 8'(-(8'h01 + 8'hFE + 8'h02 + 8'h01 + 8'h02));
        send_stim(0);
        @(negedge clk); #1;
        chk("edge_done", 32'(load_done), 32'd1);
        check_log("edge", 2, 24'h01FE01, 24'h01FF02, 24'h0);

        // Zero length
        wlog.delete();
        stim = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stim(0);
        @(negedge clk); #1;
        chk("zero_err", 32'(load_err), 32'd1);
        check_log("zero", 0, 24'h0, 24'h0, 24'h0);

        // Good load, junk, then reload with gaps and a SYNC value inside the payload
        stim = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_stim(0);
        stim = '{8'h00, 8'hFF};
        send_stim(2);
        @(negedge clk); #1;
        chk("junk_done", 32'(load_done), 32'd1);
        send(8'hA5, 1);
        @(negedge clk); #1;
        chk("reload_core_rst", 32'(core_rst), 32'd1);
        chk("reload_done_clr", 32'(load_done), 32'd0);
        wlog.delete();
        stim = '{8'h01, 8'h00, 8'h00, 8'h03, 8'hDE, 8'hA5, 8'hBE, 8'h00};
        stim[7] = 8'(-(8'h01 + 8'h03 + 8'hDE + 8'hA5 + 8'hBE));
        send_stim(3);
        @(negedge clk); #1;
        chk("reload_done", 32'(load_done), 32'd1);
        chk("reload_core_rst_low", 32'(core_rst), 32'd0);
        check_log("reload", 3, 24'h0100DE, 24'h0101A5, 24'h0102BE);

        // Reset after the first of three payload bytes
        stim = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11};
        send_stim(0);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(prog_we), 32'd0);
        chk("midrst_core_rst", 32'(core_rst), 32'd1);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_bw", 32'(bytes_written), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wlog.delete();
        stim = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_stim(0);
        @(negedge clk); #1;
        chk("post_rst_done", 32'(load_done), 32'd1);
        chk("post_rst_bw", 32'(bytes_written), 32'd3);
        check_log("post_rst", 3, 24'h001011, 24'h001122, 24'h001233);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
